addsub_result_stage: RTL and testbench
======================================

Name: addsub_result_stage

Overview:
- Registered output stage directly downstream of the 16-bit adder-subtractor.
- Captures the sum, carry-out, subtract-enable and operand sign bits. Derives the N/Z/C/V status flags.
- Buffers result plus flags in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Keeps a saturating count of overflowed results for the ALU status logic.

Parameters:
- WIDTH, 16, datapath width; must equal adder-subtractor width.
- CNT_W, 8, width of overflow event counter.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream result valid
- in_ready  output  1  stage can accept a result this cycle
- in_sum  input  WIDTH  adder-subtractor s
- in_cout  input  1  adder-subtractor cout
- in_sub  input  1  adder-subtractor enable (1 = a-b)
- in_a_msb  input  1  operand a[WIDTH-1]
- in_b_msb  input  1  operand b[WIDTH-1] (un-inverted)
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts head
- out_result  output  WIDTH  head result
- out_flags  output  4  head flags {N,Z,C,V}
- clr_cnt  input  1  synchronous clear of ovf_cnt
- ovf_cnt  output  CNT_W  saturating count of accepted results with V=1

Behaviour:
- Clock and reset: one clock clk. Reset rst is synchronous, active-high.
- Reset state: count=0, out_valid=0, out_result=0, out_flags=0, ovf_cnt=0, in_ready=1 in the cycle after reset.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count != 2). It depends only on registered state, with no combinational path from out_ready.
  - out_valid = (count != 0).
- Flags, computed combinationally on input and stored with the entry:
  - N = in_sum[WIDTH-1].
  - Z = (in_sum == 0).
  - C = in_cout, raw. For subtract, C=1 means no borrow.
  - V, add: (in_a_msb == in_b_msb) & (in_sum msb != in_a_msb).
  - V, subtract: (in_a_msb != in_b_msb) & (in_sum msb != in_a_msb).
- Latency and throughput:
  - Accepted at edge t, the entry is visible on out_* after edge t (1 cycle).
  - Sustains 1 result/cycle when out_ready is held high.
- Buffer: 2 entries, FIFO order, head drives out_*.
  - count 0, push: entry becomes head.
  - count 1, push & pop: head is replaced by the new entry; count stays 1.
  - count 1, push only: entry goes to skid slot; count becomes 2.
  - count 2, pop: skid slot moves to head; count becomes 1. No push is possible since in_ready=0.
  - No push/pop: outputs hold stable. While out_valid=1 & out_ready=0, out_result/out_flags must not change.
- Empty outputs: when count=0, out_result/out_flags hold the last popped value (don't-care for consumers).
- ovf_cnt:
  - Increments on push when V=1 (or the saturation event with the optional feature).
  - Saturates at 2^CNT_W-1 with no wrap.
  - clr_cnt has priority over increment in the same cycle. rst clears it.
- Reset mid-operation: rst wins over push/pop in the same cycle; all buffered entries are discarded.
- Overlapping-width rules: in_sum is not modified except by the optional feature below. Flags are always derived from the unsaturated sum.

Optional Feature:
- Macro: ADDSUB_RESULT_SATURATE_EN.
- Defined: when V=1 on push, the stored result is clamped.
  - Clamp value is 2^(WIDTH-1)-1 (0x7FFF) if in_a_msb=0, else 2^(WIDTH-1) (0x8000).
  - N and Z are recomputed from the clamped value. C and V remain from the raw result.
- Not defined: result is stored unmodified; no clamp logic is present.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, ovf_cnt=0, out_flags=0.
- Add 0x7FFF+0x0001 (sum=0x8000, cout=0, a_msb=0, b_msb=0), out_ready=1 -> next cycle out_result=0x8000, flags N=1 Z=0 C=0 V=1, ovf_cnt=1. With SATURATE_EN: out_result=0x7FFF, N=0.
- Sub 0x0005-0x0005 (sum=0x0000, cout=1, sub=1) -> flags N=0 Z=1 C=1 V=0. Sub 0x0003-0x0005 (sum=0xFFFE, cout=0) -> N=1 Z=0 C=0 V=0.
- out_ready=0, push R1 then R2 -> in_ready=0 after the 2nd push and out_result=R1 held stable. Raise out_ready -> R1 then R2 appear in order and in_ready returns to 1.
- Continuous stream of 10 pushes with out_ready=1 -> 10 pops on consecutive cycles, in_ready never drops.
- Force 300 V=1 pushes with CNT_W=8 -> ovf_cnt stops at 255. Assert clr_cnt together with an overflow push -> ovf_cnt=0. Assert rst with count=2 -> out_valid=0 on the next cycle.

Source files
------------

// File: rtl/addsub_result_stage_if.sv
// ============================================================================
// Module      : addsub_result_stage_if
// Description : Upstream/downstream handshake bundle for addsub_result_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface addsub_result_stage_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic             in_cout;
  logic             in_sub;
  logic             in_a_msb;
  logic             in_b_msb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;

  // Producer of results and consumer of the buffered head.
  modport master (
    output in_valid, in_sum, in_cout, in_sub, in_a_msb, in_b_msb, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_sum, in_cout, in_sub, in_a_msb, in_b_msb, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

`default_nettype wire

// File: rtl/addsub_result_stage.sv
// ============================================================================
// Module      : addsub_result_stage
// Description : Adder-subtractor result register: N/Z/C/V flags, 2-entry skid
//               buffer and saturating overflow counter.
//               Optional clamp of overflowed results: ADDSUB_RESULT_SATURATE_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_result_stage #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  addsub_result_stage_if.slave  bus,
  input  wire logic             clr_cnt,
  output logic [CNT_W-1:0]      ovf_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_head_res;
  logic [3:0]       r_head_flags;
  logic [WIDTH-1:0] r_skid_res;
  logic [3:0]       r_skid_flags;
  logic [CNT_W-1:0] r_ovf_cnt;

  logic             w_push;
  logic             w_pop;
  logic             w_raw_msb;
  logic             w_v;
  logic [WIDTH-1:0] w_res;
  logic [3:0]       w_flags;

  assign w_raw_msb = bus.in_sum[WIDTH-1];
  // Subtract inverts b inside the adder, so overflow needs differing signs.
  assign w_v = ((bus.in_a_msb ^ bus.in_b_msb) == bus.in_sub) &&
               (w_raw_msb != bus.in_a_msb);

`ifdef ADDSUB_RESULT_SATURATE_EN
  logic [WIDTH-1:0] w_clamp;
  assign w_clamp = bus.in_a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
  assign w_res   = w_v ? w_clamp : bus.in_sum;
`else
  assign w_res   = bus.in_sum;
`endif

  assign w_flags = {w_res[WIDTH-1], (w_res == '0), bus.in_cout, w_v};

  assign bus.in_ready   = (r_count != 2'd2);
  assign bus.out_valid  = (r_count != 2'd0);
  assign bus.out_result = r_head_res;
  assign bus.out_flags  = r_head_flags;
  assign ovf_cnt        = r_ovf_cnt;

  assign w_push = bus.in_valid & bus.in_ready;
  assign w_pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= 2'd0;
      r_head_res   <= '0;
      r_head_flags <= 4'd0;
      r_skid_res   <= '0;
      r_skid_flags <= 4'd0;
    end else if (w_push && w_pop) begin
      // Only reachable with one entry: replace head in place.
      r_head_res   <= w_res;
      r_head_flags <= w_flags;
    end else if (w_push) begin
      if (r_count == 2'd0) begin
        r_head_res   <= w_res;
        r_head_flags <= w_flags;
      end else begin
        r_skid_res   <= w_res;
        r_skid_flags <= w_flags;
      end
      r_count <= r_count + 2'd1;
    end else if (w_pop) begin
      if (r_count == 2'd2) begin
        r_head_res   <= r_skid_res;
        r_head_flags <= r_skid_flags;
      end
      r_count <= r_count - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_ovf_cnt <= '0;
    end else if (w_push && w_v && (r_ovf_cnt != c_cnt_max)) begin
      r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_addsub_result_stage.sv
// ============================================================================
// Module      : tb_addsub_result_stage
// Description : Directed self-checking bench for addsub_result_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addsub_result_stage;

  logic       clk;
  logic       rst;
  logic       clr_cnt;
  logic [7:0] ovf_cnt;
  int         n_checks;
  int         n_fail;
  int         exp_ovf;

  addsub_result_stage_if #(.WIDTH(16)) bus ();

  addsub_result_stage #(.WIDTH(16), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .clr_cnt (clr_cnt),
    .ovf_cnt (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] s, input logic co, input logic sb,
                       input logic am, input logic bm);
    bus.in_valid = 1'b1;
    bus.in_sum   = s;
    bus.in_cout  = co;
    bus.in_sub   = sb;
    bus.in_a_msb = am;
    bus.in_b_msb = bm;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_checks++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_ovf_cnt got %0d want 0", ovf_cnt); end
    n_checks++; if (bus.out_flags !== 4'd0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", bus.out_flags); end
    n_checks++; if (bus.out_result !== 16'd0) begin n_fail++; $display("FAIL reset_result got %h want 0000", bus.out_result); end
    step();
    exp_ovf = 0;
  endtask

  // One result through an empty buffer with out_ready high.
  task automatic test_flags();
    logic [15:0] vs [7];
    logic        vc [7];
    logic        vsub [7];
    logic        va [7];
    logic        vb [7];
    logic [15:0] er [7];
    logic [3:0]  ef [7];
    logic        ev [7];
    // 0x7FFF+0x0001
    vs[0] = 16'h8000; vc[0] = 0; vsub[0] = 0; va[0] = 0; vb[0] = 0; ev[0] = 1;
`ifdef ADDSUB_RESULT_SATURATE_EN
    er[0] = 16'h7FFF; ef[0] = 4'b0001;
`else
    er[0] = 16'h8000; ef[0] = 4'b1001;
`endif
    // 0x0005-0x0005
    vs[1] = 16'h0000; vc[1] = 1; vsub[1] = 1; va[1] = 0; vb[1] = 0; ev[1] = 0;
    er[1] = 16'h0000; ef[1] = 4'b0110;
    // 0x0003-0x0005
    vs[2] = 16'hFFFE; vc[2] = 0; vsub[2] = 1; va[2] = 0; vb[2] = 0; ev[2] = 0;
    er[2] = 16'hFFFE; ef[2] = 4'b1000;
    // 0x1234+0x0001
    vs[3] = 16'h1235; vc[3] = 0; vsub[3] = 0; va[3] = 0; vb[3] = 0; ev[3] = 0;
    er[3] = 16'h1235; ef[3] = 4'b0000;
    // 0x8000+0xFFFF
    vs[4] = 16'h7FFF; vc[4] = 1; vsub[4] = 0; va[4] = 1; vb[4] = 1; ev[4] = 1;
`ifdef ADDSUB_RESULT_SATURATE_EN
    er[4] = 16'h8000; ef[4] = 4'b1011;
`else
    er[4] = 16'h7FFF; ef[4] = 4'b0011;
`endif
    // 0x8000-0x0001
    vs[5] = 16'h7FFF; vc[5] = 1; vsub[5] = 1; va[5] = 1; vb[5] = 0; ev[5] = 1;
`ifdef ADDSUB_RESULT_SATURATE_EN
    er[5] = 16'h8000; ef[5] = 4'b1011;
`else
    er[5] = 16'h7FFF; ef[5] = 4'b0011;
`endif
    // 0x7FFF-0xFFFF (=0x8000 signed overflow)
    vs[6] = 16'h8000; vc[6] = 0; vsub[6] = 1; va[6] = 0; vb[6] = 1; ev[6] = 1;
`ifdef ADDSUB_RESULT_SATURATE_EN
    er[6] = 16'h7FFF; ef[6] = 4'b0001;
`else
    er[6] = 16'h8000; ef[6] = 4'b1001;
`endif
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(vs[i], vc[i], vsub[i], va[i], vb[i]);
      step();
      bus.in_valid = 1'b0;
      if (ev[i]) exp_ovf++;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL flags_valid[%0d] got %b want 1", i, bus.out_valid); end
      n_checks++; if (bus.out_result !== er[i]) begin n_fail++; $display("FAIL flags_result[%0d] got %h want %h", i, bus.out_result, er[i]); end
      n_checks++; if (bus.out_flags !== ef[i]) begin n_fail++; $display("FAIL flags_nzcv[%0d] got %b want %b", i, bus.out_flags, ef[i]); end
      n_checks++; if (ovf_cnt !== 8'(exp_ovf)) begin n_fail++; $display("FAIL flags_ovf_cnt[%0d] got %0d want %0d", i, ovf_cnt, exp_ovf); end
      step();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flags_drain[%0d] got %b want 0", i, bus.out_valid); end
    end
  endtask

  task automatic test_skid();
    bus.out_ready = 1'b0;
    drive(16'h1111, 0, 0, 0, 0);
    step();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_ready1 got %b want 1", bus.in_ready); end
    drive(16'h2222, 0, 0, 0, 0);
    step();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_full_ready got %b want 0", bus.in_ready); end
    n_checks++; if (bus.out_result !== 16'h1111) begin n_fail++; $display("FAIL skid_head got %h want 1111", bus.out_result); end
    bus.in_valid = 1'b1;
    bus.in_sum   = 16'h3333;
    step();
    step();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_result !== 16'h1111) begin n_fail++; $display("FAIL skid_hold got %h want 1111", bus.out_result); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL skid_hold_valid got %b want 1", bus.out_valid); end
    bus.out_ready = 1'b1;
    step();
    n_checks++; if (bus.out_result !== 16'h2222) begin n_fail++; $display("FAIL skid_second got %h want 2222", bus.out_result); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_ready_back got %b want 1", bus.in_ready); end
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL skid_empty got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got %b want 1", i, bus.in_ready); end
      drive(16'h0100 + 16'(i), 0, 0, 0, 0);
      step();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h0100 + 16'(i)) begin
        n_fail++; $display("FAIL stream_out[%0d] got v=%b %h want v=1 %h", i, bus.out_valid, bus.out_result, 16'h0100 + 16'(i));
      end
    end
    bus.in_valid = 1'b0;
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_ovf_saturate();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    n_checks++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL ovf_clear got %0d want 0", ovf_cnt); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive(16'h8000, 0, 0, 0, 0);
      step();
      if (i == 254) begin
        n_checks++; if (ovf_cnt !== 8'd255) begin n_fail++; $display("FAIL ovf_reach_max got %0d want 255", ovf_cnt); end
      end
    end
    bus.in_valid = 1'b0;
    step();
    n_checks++; if (ovf_cnt !== 8'd255) begin n_fail++; $display("FAIL ovf_saturate got %0d want 255", ovf_cnt); end
    clr_cnt = 1'b1;
    drive(16'h8000, 0, 0, 0, 0);
    step();
    clr_cnt = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL ovf_clr_priority got %0d want 0", ovf_cnt); end
    step();
  endtask

  task automatic test_reset_midop();
    bus.out_ready = 1'b0;
    drive(16'h8000, 0, 0, 0, 0);
    step();
    drive(16'h4444, 0, 0, 0, 0);
    step();
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_full got %b want 0", bus.in_ready); end
    n_checks++; if (ovf_cnt !== 8'd1) begin n_fail++; $display("FAIL midrst_ovf_pre got %0d want 1", ovf_cnt); end
    rst = 1'b1;
    bus.out_ready = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", bus.in_ready); end
    n_checks++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_ovf got %0d want 0", ovf_cnt); end
    n_checks++; if (bus.out_result !== 16'd0) begin n_fail++; $display("FAIL midrst_result got %h want 0000", bus.out_result); end
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stay_empty got %b want 0", bus.out_valid); end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    exp_ovf       = 0;
    rst           = 1'b1;
    clr_cnt       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sum    = 16'd0;
    bus.in_cout   = 1'b0;
    bus.in_sub    = 1'b0;
    bus.in_a_msb  = 1'b0;
    bus.in_b_msb  = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_flags();
    test_skid();
    test_back_to_back();
    test_ovf_saturate();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
